// File: rtl/custom_axi_engine.sv
// Iterative accumulate engine. A job adds step to a seed iter times and writes the
// sum into one of NUM_CH result channels. Overflow, zero-length jobs and abort end in ERROR.
module custom_axi_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [$clog2(NUM_CH)-1:0]    ch_sel_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic [DATA_WIDTH-1:0]        step_i,
  input  logic [CNT_WIDTH-1:0]         iter_i,
  input  logic                         abort_i,
  input  logic                         clear_err_i,
  output logic [1:0]                   status_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] result_o,
  output logic [NUM_CH-1:0]            result_valid_o,
  output logic [1:0]                   err_code_o,
  output logic [CNT_WIDTH-1:0]         iter_left_o
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OVF   = 2'd1;
  localparam logic [1:0] ERR_ZERO  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   acc_reg;
  logic [DATA_WIDTH-1:0]   step_reg;
  logic [CH_W-1:0]         ch_reg;
  logic [CNT_WIDTH-1:0]    cnt_reg;
  logic [1:0]              err_reg;
  logic [DATA_WIDTH-1:0]   result_reg [NUM_CH];
  logic [NUM_CH-1:0]       valid_reg;

  logic [DATA_WIDTH:0]     sum_next;
  logic                    ch_ok;

  // The extra top bit of the sum is the carry that flags overflow.
  assign sum_next = {1'b0, acc_reg} + {1'b0, step_reg};
  assign ch_ok    = (int'(ch_sel_i) < NUM_CH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      step_reg  <= '0;
      ch_reg    <= '0;
      cnt_reg   <= '0;
      err_reg   <= ERR_NONE;
      valid_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        result_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            if (iter_i == '0 || !ch_ok) begin
              state_reg <= S_ERROR;
              err_reg   <= ERR_ZERO;
            end else begin
              state_reg           <= S_BUSY;
              acc_reg             <= data_i;
              step_reg            <= step_i;
              cnt_reg             <= iter_i;
              ch_reg              <= ch_sel_i;
              valid_reg[ch_sel_i] <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          // Abort outranks overflow, which outranks completion.
          if (abort_i) begin
            state_reg <= S_ERROR;
            err_reg   <= ERR_ABORT;
            cnt_reg   <= '0;
          end else if (sum_next[DATA_WIDTH]) begin
            state_reg <= S_ERROR;
            err_reg   <= ERR_OVF;
            cnt_reg   <= '0;
          end else begin
            acc_reg <= sum_next[DATA_WIDTH-1:0];
            cnt_reg <= cnt_reg - CNT_WIDTH'(1);
            if (cnt_reg == CNT_WIDTH'(1)) begin
              result_reg[ch_reg] <= sum_next[DATA_WIDTH-1:0];
              valid_reg[ch_reg]  <= 1'b1;
              state_reg          <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        S_ERROR: begin
          if (clear_err_i) begin
            state_reg <= S_IDLE;
            err_reg   <= ERR_NONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_result
      assign result_o[gi*DATA_WIDTH +: DATA_WIDTH] = result_reg[gi];
    end
  endgenerate

  assign status_o       = state_reg;
  assign busy_o         = (state_reg == S_BUSY);
  assign done_o         = (state_reg == S_DONE);
  assign result_valid_o = valid_reg;
  assign err_code_o     = err_reg;
  assign iter_left_o    = cnt_reg;

endmodule

// File: tb/tb_custom_axi_engine.sv
// Randomised bench for custom_axi_engine. Each job's outcome is predicted by a plain
// arithmetic model of the accumulate rules and compared cycle by cycle.
module tb_custom_axi_engine;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               start_i;
  logic [1:0]         ch_sel_i;
  logic [DW-1:0]      data_i;
  logic [DW-1:0]      step_i;
  logic [CW-1:0]      iter_i;
  logic               abort_i;
  logic               clear_err_i;
  logic [1:0]         status_o;
  logic               busy_o;
  logic               done_o;
  logic [NC*DW-1:0]   result_o;
  logic [NC-1:0]      result_valid_o;
  logic [1:0]         err_code_o;
  logic [CW-1:0]      iter_left_o;

  custom_axi_engine #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ch_sel_i(ch_sel_i),
    .data_i(data_i), .step_i(step_i), .iter_i(iter_i), .abort_i(abort_i),
    .clear_err_i(clear_err_i), .status_o(status_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .result_valid_o(result_valid_o), .err_code_o(err_code_o),
    .iter_left_o(iter_left_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_res [NC];
  logic [NC-1:0] exp_valid;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one job and checks it against the model; abort_at is the BUSY cycle
  // (1-based) in which abort_i is raised, 0 for none.
  task automatic run_job(input logic [DW-1:0] d, input logic [DW-1:0] s,
                         input logic [CW-1:0] n, input logic [1:0] ch,
                         input int abort_at, input bit start_in_done);
    longint unsigned acc;
    int end_k;
    int outcome;
    acc = 64'(d);
    end_k = int'(n);
    outcome = 0;
    if (n == 0) begin
      outcome = 2;
      end_k = 0;
    end
    for (int k = 1; k <= int'(n); k++) begin
      if (k == abort_at) begin
        end_k = k; outcome = 3; break;
      end
      acc = acc + 64'(s);
      if (acc > 64'hFFFF_FFFF) begin
        end_k = k; outcome = 1; break;
      end
    end

    start_i = 1'b1; data_i = d; step_i = s; iter_i = n; ch_sel_i = ch;
    tick();
    start_i = 1'b0;
    if (n != 0) exp_valid[ch] = 1'b0;

    for (int k = 1; k <= end_k; k++) begin
      checks++;
      if (status_o !== 2'd1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL busy_state k=%0d got status=%0d busy=%0b done=%0b exp status=1 busy=1 done=0",
                 k, status_o, busy_o, done_o);
      end
      checks++;
      if (iter_left_o !== CW'(int'(n) - k + 1)) begin
        errors++;
        $display("FAIL iter_left k=%0d got %0d exp %0d", k, iter_left_o, int'(n) - k + 1);
      end
      if (k == 1) begin
        checks++;
        if (result_valid_o !== exp_valid) begin
          errors++;
          $display("FAIL valid_at_accept got %b exp %b", result_valid_o, exp_valid);
        end
      end
      // Start and a different channel during BUSY must not disturb the job.
      start_i = (k == 2);
      ch_sel_i = ch + 2'd1;
      abort_i = (k == abort_at);
      tick();
      abort_i = 1'b0;
      start_i = 1'b0;
    end

    if (outcome == 0) begin
      exp_res[ch] = acc[DW-1:0];
      exp_valid[ch] = 1'b1;
      checks++;
      if (status_o !== 2'd2 || done_o !== 1'b1 || busy_o !== 1'b0 || iter_left_o !== '0 || err_code_o !== 2'd0) begin
        errors++;
        $display("FAIL done_state got status=%0d done=%0b busy=%0b left=%0d err=%0d exp 2 1 0 0 0",
                 status_o, done_o, busy_o, iter_left_o, err_code_o);
      end
    end else begin
      checks++;
      if (status_o !== 2'd3 || err_code_o !== 2'(outcome) || done_o !== 1'b0 || iter_left_o !== '0) begin
        errors++;
        $display("FAIL error_state got status=%0d err=%0d done=%0b left=%0d exp 3 %0d 0 0",
                 status_o, err_code_o, done_o, iter_left_o, outcome);
      end
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (result_o[c*DW +: DW] !== exp_res[c]) begin
        errors++;
        $display("FAIL result ch%0d got %h exp %h", c, result_o[c*DW +: DW], exp_res[c]);
      end
    end
    checks++;
    if (result_valid_o !== exp_valid) begin
      errors++;
      $display("FAIL result_valid got %b exp %b", result_valid_o, exp_valid);
    end

    if (outcome == 0) begin
      if (start_in_done) begin
        start_i = 1'b1; iter_i = 8'd5; ch_sel_i = ch;
      end
      tick();
      start_i = 1'b0;
      checks++;
      if (status_o !== 2'd0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL after_done got status=%0d done=%0b exp 0 0", status_o, done_o);
      end
    end else begin
      start_i = 1'b1; iter_i = 8'd3; ch_sel_i = ch;
      tick();
      start_i = 1'b0;
      checks++;
      if (status_o !== 2'd3 || err_code_o !== 2'(outcome)) begin
        errors++;
        $display("FAIL error_hold got status=%0d err=%0d exp 3 %0d", status_o, err_code_o, outcome);
      end
      clear_err_i = 1'b1; start_i = 1'b1;
      tick();
      clear_err_i = 1'b0; start_i = 1'b0;
      checks++;
      if (status_o !== 2'd0 || err_code_o !== 2'd0) begin
        errors++;
        $display("FAIL clear_err got status=%0d err=%0d exp 0 0", status_o, err_code_o);
      end
      tick();
      checks++;
      if (status_o !== 2'd0) begin
        errors++;
        $display("FAIL start_with_clear got status=%0d exp 0", status_o);
      end
    end
    $display("job d=%h s=%h n=%0d ch=%0d abort_at=%0d -> outcome=%0d end_k=%0d",
             d, s, n, ch, abort_at, outcome, end_k);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; clear_err_i = 1'b0;
    ch_sel_i = '0; data_i = '0; step_i = '0; iter_i = '0;
    for (int c = 0; c < NC; c++) exp_res[c] = '0;
    exp_valid = '0;
    repeat (2) tick();
    checks++;
    if (status_o !== 2'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 ||
        result_valid_o !== '0 || err_code_o !== 2'd0 || iter_left_o !== '0) begin
      errors++;
      $display("FAIL reset_state got status=%0d busy=%0b done=%0b res=%h valid=%b err=%0d left=%0d exp all 0",
               status_o, busy_o, done_o, result_o, result_valid_o, err_code_o, iter_left_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_basic();
    run_job(32'd10, 32'd3, 8'd4, 2'd2, 0, 1'b0);
  endtask

  task automatic test_overflow();
    run_job(32'hFFFF_FFFE, 32'd1, 8'd3, 2'd0, 0, 1'b0);
  endtask

  task automatic test_zero_iter();
    run_job(32'd123, 32'd1, 8'd0, 2'd1, 0, 1'b0);
  endtask

  task automatic test_abort();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (status_o !== 2'd0 || err_code_o !== 2'd0) begin
      errors++;
      $display("FAIL abort_in_idle got status=%0d err=%0d exp 0 0", status_o, err_code_o);
    end
    run_job(32'd5, 32'd1, 8'd10, 2'd1, 3, 1'b0);
    // Abort on the final increment still wins over completion.
    run_job(32'd1, 32'd1, 8'd2, 2'd3, 2, 1'b0);
  endtask

  task automatic test_reset_midjob();
    start_i = 1'b1; data_i = 32'd100; step_i = 32'd4; iter_i = 8'd10; ch_sel_i = 2'd3;
    tick();
    start_i = 1'b0;
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) exp_res[c] = '0;
    exp_valid = '0;
    checks++;
    if (status_o !== 2'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 ||
        result_valid_o !== '0 || err_code_o !== 2'd0 || iter_left_o !== '0) begin
      errors++;
      $display("FAIL async_reset got status=%0d busy=%0b res=%h valid=%b err=%0d left=%0d exp all 0",
               status_o, busy_o, result_o, result_valid_o, err_code_o, iter_left_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    run_job(32'd7, 32'd2, 8'd1, 2'd3, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job(32'd1000, 32'd7, 8'd3, 2'd0, 0, 1'b1);
    run_job(32'd2000, 32'd9, 8'd2, 2'd0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 30; j++) begin
      logic [DW-1:0] d, s;
      logic [CW-1:0] n;
      logic [1:0] ch;
      int ab;
      d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 40))) : $urandom;
      s = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      n = CW'($urandom_range(0, 8));
      ch = 2'($urandom_range(0, 3));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_job(d, s, n, ch, ab, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero_iter();
    test_abort();
    test_reset_midjob();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/custom_axi_engine.md
CUSTOM_AXI_ENGINE -- requirements
Module: custom_axi_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, which sets the width of the datapath, step and result words.
REQ-002 SHALL have parameter NUM_CH, default 4, which sets the number of result channels (>=2).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, which sets the width of the iteration counter.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  request a job; sampled only in IDLE.
REQ-007 ch_sel_i  input  $clog2(NUM_CH)  target channel for the job.
REQ-008 data_i  input  DATA_WIDTH  initial accumulator value.
REQ-009 step_i  input  DATA_WIDTH  increment added once per BUSY cycle.
REQ-010 iter_i  input  CNT_WIDTH  number of increments to perform.
REQ-011 abort_i  input  1  cancel the running job.
REQ-012 clear_err_i  input  1  leave the ERROR state.
REQ-013 status_o  output  2  state encoding: IDLE=0, BUSY=1, DONE=2, ERROR=3.
REQ-014 busy_o  output  1  high iff status_o==BUSY.
REQ-015 done_o  output  1  one-cycle pulse, high iff status_o==DONE.
REQ-016 result_o  output  NUM_CH*DATA_WIDTH  per-channel result registers; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-017 result_valid_o  output  NUM_CH  per-channel sticky valid flags.
REQ-018 err_code_o  output  2  error code: 0=none, 1=overflow, 2=zero iterations, 3=abort.
REQ-019 iter_left_o  output  CNT_WIDTH  remaining iterations of the current job.

Function
REQ-020 IDLE, start_i=1, iter_i!=0: SHALL capture data_i, step_i, iter_i and ch_sel_i, clear result_valid_o[ch_sel_i], and enter BUSY next cycle.
REQ-021 IDLE, start_i=1, iter_i==0: SHALL enter ERROR with err_code_o=2; no result register is changed.
REQ-022 ch_sel_i>=NUM_CH at start: SHALL be treated as an invalid request and enter ERROR with err_code_o=2.
REQ-023 BUSY: each cycle acc <= acc + step and iter_left <= iter_left-1, using a DATA_WIDTH+1-bit unsigned add.
REQ-024 BUSY, carry out of the add: SHALL enter ERROR with err_code_o=1; the accumulator and result registers are not updated.
REQ-025 BUSY, final increment (iter_left==1) with no carry: SHALL write the sum to result[ch], set result_valid_o[ch], and enter DONE.
REQ-026 Latency: with a start accepted at edge 0, BUSY SHALL hold for edges 1..N (N=iter_i) and DONE for cycle N+1; result_o already holds the new value while done_o=1.
REQ-027 DONE: SHALL last exactly one cycle, then return to IDLE; start_i is ignored during DONE.
REQ-028 start_i in BUSY, DONE or ERROR: SHALL be ignored with no side effect.
REQ-029 abort_i in BUSY: SHALL enter ERROR with err_code_o=3; abort takes priority over overflow and completion in the same cycle.
REQ-030 abort_i outside BUSY: SHALL have no effect.
REQ-031 ERROR: SHALL hold, with err_code_o held, until clear_err_i=1; then enter IDLE and set err_code_o=0.
REQ-032 clear_err_i and start_i together in ERROR: SHALL go to IDLE and ignore the start.
REQ-033 Result registers of non-selected channels SHALL never change during a job.
REQ-034 iter_left_o SHALL equal iter_i for the first BUSY cycle, decrement by 1 each BUSY cycle, and read 0 in IDLE, DONE and ERROR.

Reset
REQ-035 rst_ni=0 SHALL immediately force status_o=IDLE, busy_o=0, done_o=0, result_o=0, result_valid_o=0, err_code_o=0, iter_left_o=0, and clear the internal accumulator, step, channel and counter registers.
REQ-036 Reset asserted in any state, including mid-job, SHALL abandon the job with no result write; operation resumes on the first edge after rst_ni rises.

Verification
REQ-037 data=10, step=3, iter=4, ch=2 -> BUSY for 4 cycles, done_o at cycle 5, result[2]=22, result_valid_o=4'b0100, other channels 0.
REQ-038 data=0xFFFF_FFFE, step=1, iter=3, ch=0 -> ERROR on the 2nd BUSY edge, err_code_o=1, result[0]=0, result_valid_o[0]=0; clear_err_i -> IDLE, err_code_o=0.
REQ-039 start with iter=0 -> ERROR next cycle, err_code_o=2; a start pulse during ERROR is ignored; clear_err_i -> IDLE.
REQ-040 data=5, step=1, iter=10, ch=1, abort_i in the 3rd BUSY cycle -> ERROR, err_code_o=3, result[1] unchanged, no done_o.
REQ-041 rst_ni low in the 2nd BUSY cycle of a job to ch=3 -> all outputs 0 at once; after release, data=7, step=2, iter=1, ch=3 -> result[3]=9 with done_o at cycle 2.
REQ-042 Back-to-back jobs: ch0 job, then a start in the DONE cycle (ignored), then a start in IDLE -> only two results written, result_valid_o[0] cleared at the second accept and set again at its completion.
